mem_access_unit: RTL and testbench

Bridges the MEM stage of the MIPS 5-stage pipeline to the Wishbone-style data bus. It accepts the MEM-stage request signals (read/write enable, type, sign-extend flag, address, store data) and drives byte-lane-aligned bus cycles. It returns aligned, extended load data on `mem_din` and holds the pipeline through `mem_stall` until the access completes. Misaligned accesses and bus faults are reported to the exception logic.

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage to Wishbone data-bus bridge: lane steering, load extraction/extension, stall and fault reporting.
// Optional feature macro MEM_ALIGN_CHECK_EN: reject misaligned half/word accesses instead of force-aligning them.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [1:0]  mem_type,
    input  logic        mem_ext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_unalign,
    output logic        bus_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_dout,
    input  logic [31:0] wb_din,
    input  logic        wb_ack,
    input  logic        wb_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  lane_q;
    logic [1:0]  type_q;
    logic        ext_q;
    logic        req;
    logic        misalign;
    logic        timeout_hit;
    logic [1:0]  lane_lo;

    // Byte offset actually used on the bus: half drops a[0], word (and type 11) drops a[1:0].
    function automatic logic [1:0] align_lo(input logic [1:0] typ, input logic [1:0] lo);
        case (typ)
            2'b10:   return lo;
            2'b01:   return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] typ, input logic [1:0] lo);
        case (typ)
            2'b10:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wr_data(input logic [1:0] typ, input logic [31:0] d);
        case (typ)
            2'b10:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] rd_extract(input logic [1:0] typ, input logic ext,
                                              input logic [1:0] lo, input logic [31:0] din);
        logic [31:0] sh;
        sh = din >> {lo, 3'b000};
        case (typ)
            2'b10:   return {{24{ext & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{ext & sh[15]}}, sh[15:0]};
            default: return din;
        endcase
    endfunction

    assign req         = mem_ren | mem_wen;
    assign lane_lo     = align_lo(mem_type, mem_addr[1:0]);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == 8'(TIMEOUT - 1));

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        case (mem_type)
            2'b10:   misalign = 1'b0;
            2'b01:   misalign = req & mem_addr[0];
            default: misalign = req & (mem_addr[1:0] != 2'b00);
        endcase
    end
    assign mem_unalign = misalign;
`else
    assign misalign    = 1'b0;
    assign mem_unalign = 1'b0;
`endif

    always_comb begin
        mem_stall = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    mem_stall = req & ~misalign;
                BUSY:    mem_stall = 1'b1;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_sel  <= 4'b0000;
            wb_addr <= 32'd0;
            wb_dout <= 32'd0;
            mem_din <= 32'd0;
            bus_err <= 1'b0;
            lane_q  <= 2'b00;
            type_q  <= 2'b00;
            ext_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus_err <= 1'b0;
                    if (req && !misalign) begin
                        wb_cyc  <= 1'b1;
                        wb_stb  <= 1'b1;
                        wb_we   <= mem_wen;
                        wb_sel  <= lane_sel(mem_type, lane_lo);
                        wb_addr <= {mem_addr[31:2], 2'b00};
                        wb_dout <= wr_data(mem_type, mem_dout);
                        lane_q  <= lane_lo;
                        type_q  <= mem_type;
                        ext_q   <= mem_ext;
                        cnt     <= 8'd0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    // ack wins over err when a slave raises both in the same cycle
                    if (wb_ack) begin
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        mem_din <= wb_we ? 32'd0 : rd_extract(type_q, ext_q, lane_q, wb_din);
                        state   <= DONE;
                    end else if (wb_err || timeout_hit) begin
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        mem_din <= 32'd0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level expectation model, per-cycle compare, literal pins.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ren, mem_wen, mem_ext;
    logic [1:0]  mem_type;
    logic [31:0] mem_addr, mem_dout, mem_din;
    logic        mem_stall, mem_unalign, bus_err;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_addr, wb_dout, wb_din;
    logic        wb_ack = 1'b0, wb_err = 1'b0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_type(mem_type),
        .mem_ext(mem_ext), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_stall(mem_stall), .mem_unalign(mem_unalign), .bus_err(bus_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_addr(wb_addr),
        .wb_dout(wb_dout), .wb_din(wb_din), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Slave: mode 0 acks, mode 1 errors, mode 2 never answers; answers after s_wait wait states.
    int s_wait = 0, s_mode = 0, bcnt = 0;
    logic [31:0] s_rdata = 32'd0;
    assign wb_din = s_rdata;
    always @(posedge clk) begin
        #1;
        if (wb_cyc && wb_stb) begin
            bcnt   = bcnt + 1;
            wb_ack = (s_mode == 0) && (bcnt == s_wait + 1);
            wb_err = (s_mode == 1) && (bcnt == s_wait + 1);
        end else begin
            bcnt   = 0;
            wb_ack = 1'b0;
            wb_err = 1'b0;
        end
    end

    function automatic logic [31:0] m_sel(input logic [1:0] typ, input logic [31:0] a);
        if (typ == 2'b10) return 32'd1 << (a % 4);
        if (typ == 2'b01) return 32'd3 << (a & 32'd2);
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] typ, input logic [31:0] d);
        if (typ == 2'b10) return (d & 32'hFF) * 32'h01010101;
        if (typ == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] typ, input logic ext,
                                           input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        if (typ == 2'b10) begin
            v = (r >> (8 * (a % 4))) & 32'hFF;
            if (ext && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (typ == 2'b01) begin
            v = (r >> (8 * (a & 32'd2))) & 32'hFFFF;
            if (ext && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic logic m_unalign(input logic rq, input logic [1:0] typ, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        if (!rq) return 1'b0;
        if (typ == 2'b10) return 1'b0;
        if (typ == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Expectations for the current cycle, consumed by the compare process
    logic        exp_on = 1'b0;
    logic        exp_stall, exp_cyc, exp_err, exp_unalign, exp_chk_bus, exp_we;
    logic [31:0] exp_sel, exp_addr, exp_dout, exp_din;
    logic [31:0] last_din = 32'd0;

    always @(negedge clk) begin
        if (exp_on) begin
            chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
            chk("wb_cyc", 32'(wb_cyc), 32'(exp_cyc));
            chk("wb_stb", 32'(wb_stb), 32'(exp_cyc));
            chk("bus_err", 32'(bus_err), 32'(exp_err));
            chk("mem_unalign", 32'(mem_unalign), 32'(exp_unalign));
            chk("mem_din", mem_din, exp_din);
            if (exp_chk_bus) begin
                chk("wb_sel", 32'(wb_sel), exp_sel);
                chk("wb_addr", wb_addr, exp_addr);
                chk("wb_we", 32'(wb_we), 32'(exp_we));
                chk("wb_dout", wb_dout, exp_dout);
            end
        end
    end

    task automatic run_txn(input logic ren, input logic wen, input logic [1:0] typ, input logic ext,
                           input logic [31:0] addr, input logic [31:0] dout,
                           input int wt, input int md, input logic [31:0] rdata,
                           output logic [31:0] g_din, output logic [31:0] g_sel,
                           output logic [31:0] g_addr, output logic [31:0] g_dout,
                           output logic g_we, output logic g_err, output int g_stalls);
        int blen;
        logic fault;
        logic [31:0] m_din;
        blen  = (md == 2) ? TO : wt + 1;
        fault = (md != 0);
        m_din = (fault || wen) ? 32'd0 : m_load(typ, ext, addr, rdata);
        s_wait = wt; s_mode = md; s_rdata = rdata;
        mem_ren = ren; mem_wen = wen; mem_type = typ; mem_ext = ext;
        mem_addr = addr; mem_dout = dout;
        g_stalls = 0;
        g_din = 32'd0; g_sel = 32'd0; g_addr = 32'd0; g_dout = 32'd0; g_we = 1'b0; g_err = 1'b0;
        for (int c = 0; c <= blen + 3; c++) begin
            if (c == blen + 2) begin
                mem_ren = 1'b0;
                mem_wen = 1'b0;
            end
            exp_stall   = (c <= blen);
            exp_cyc     = (c >= 1) && (c <= blen);
            exp_err     = (c == blen + 1) && fault;
            exp_unalign = m_unalign(mem_ren | mem_wen, typ, addr);
            exp_chk_bus = exp_cyc;
            exp_sel     = m_sel(typ, addr);
            exp_addr    = addr & 32'hFFFFFFFC;
            exp_we      = wen;
            exp_dout    = m_wdata(typ, dout);
            exp_din     = (c >= blen + 1) ? m_din : last_din;
            exp_on      = 1'b1;
            @(negedge clk);
            if (mem_stall) g_stalls++;
            if (c == 1) begin
                g_sel = 32'(wb_sel); g_addr = wb_addr; g_dout = wb_dout; g_we = wb_we;
            end
            if (c == blen + 1) begin
                g_din = mem_din; g_err = bus_err;
            end
            @(posedge clk);
            #1;
        end
        exp_on   = 1'b0;
        last_din = m_din;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] d, s, a, o;
    logic        w, e;
    int          st;

    initial begin
        rst_n = 1'b0;
        mem_ren = 1'b1; mem_wen = 1'b0; mem_type = 2'b00; mem_ext = 1'b0;
        mem_addr = 32'h100; mem_dout = 32'd0;
        @(posedge clk); #1;
        // Reset: everything zero, stall low even with a request pending
        exp_stall = 0; exp_cyc = 0; exp_err = 0; exp_unalign = 0; exp_chk_bus = 1;
        exp_sel = 0; exp_addr = 0; exp_we = 0; exp_dout = 0; exp_din = 0;
        exp_on = 1'b1;
        repeat (2) begin @(negedge clk); @(posedge clk); #1; end
        mem_ren = 1'b0; rst_n = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        exp_on = 1'b0;

        run_txn(1, 0, 2'b00, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF, d, s, a, o, w, e, st);
        chk("word_load_stalls", 32'(st), 32'd2);
        chk("word_load_sel", s, 32'hF);
        chk("word_load_addr", a, 32'h100);
        chk("word_load_din", d, 32'hDEADBEEF);

        run_txn(1, 0, 2'b10, 1, 32'h103, 0, 0, 0, 32'h80112233, d, s, a, o, w, e, st);
        chk("byte_sext_sel", s, 32'h8);
        chk("byte_sext_din", d, 32'hFFFFFF80);

        run_txn(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 3, 0, 32'h0, d, s, a, o, w, e, st);
        chk("half_store_we", 32'(w), 32'd1);
        chk("half_store_sel", s, 32'hC);
        chk("half_store_dout", o, 32'hABCDABCD);
        chk("half_store_stalls", 32'(st), 32'd5);

        run_txn(1, 0, 2'b10, 0, 32'h103, 0, 0, 0, 32'h80112233, d, s, a, o, w, e, st);
        chk("byte_zext_din", d, 32'h00000080);

        run_txn(1, 0, 2'b00, 0, 32'h400, 0, 1, 1, 32'h55AA55AA, d, s, a, o, w, e, st);
        chk("wb_err_bus_err", 32'(e), 32'd1);
        chk("wb_err_din", d, 32'd0);
        chk("wb_err_stalls", 32'(st), 32'd3);

        run_txn(1, 0, 2'b01, 1, 32'h106, 0, 0, 0, 32'h9ABC1234, d, s, a, o, w, e, st);
        chk("half_sext_din", d, 32'hFFFF9ABC);

        run_txn(1, 0, 2'b00, 0, 32'h500, 0, 0, 2, 32'h12345678, d, s, a, o, w, e, st);
        chk("timeout_bus_err", 32'(e), 32'd1);
        chk("timeout_din", d, 32'd0);
        chk("timeout_stalls", 32'(st), 32'(TO + 1));

        run_txn(1, 1, 2'b11, 0, 32'h600, 32'h11223344, 0, 0, 32'hFFFFFFFF, d, s, a, o, w, e, st);
        chk("rw_both_we", 32'(w), 32'd1);
        chk("rw_both_din", d, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        mem_ren = 1'b1; mem_wen = 1'b0; mem_type = 2'b00; mem_addr = 32'h102;
        exp_stall = 0; exp_cyc = 0; exp_err = 0; exp_unalign = 1; exp_chk_bus = 0;
        exp_din = last_din; exp_on = 1'b1;
        repeat (3) begin @(negedge clk); @(posedge clk); #1; end
        mem_ren = 1'b0; exp_unalign = 0;
        @(negedge clk); @(posedge clk); #1;
        exp_on = 1'b0;
`else
        run_txn(1, 0, 2'b00, 0, 32'h102, 0, 0, 0, 32'hCAFEF00D, d, s, a, o, w, e, st);
        chk("force_align_addr", a, 32'h100);
        chk("force_align_din", d, 32'hCAFEF00D);
`endif

        // Reset during the 2nd BUSY cycle abandons the access without a fault
        s_mode = 2; s_wait = 0;
        mem_ren = 1'b1; mem_wen = 1'b0; mem_type = 2'b00; mem_addr = 32'h700;
        @(negedge clk);
        chk("rst_mid_req_stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_busy_cyc", 32'(wb_cyc), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall_in_rst", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_mid_stall", 32'(mem_stall), 32'd0);
        chk("rst_mid_bus_err", 32'(bus_err), 32'd0);
        mem_ren = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_bus_err", 32'(bus_err), 32'd0);
        chk("rst_after_din", mem_din, 32'd0);
        @(posedge clk); #1;
        last_din = 32'd0;

        run_txn(1, 0, 2'b10, 1, 32'h801, 0, 2, 0, 32'h00007F00, d, s, a, o, w, e, st);
        chk("recover_byte_din", d, 32'h0000007F);
        chk("recover_stalls", 32'(st), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
